// File: rtl/adc_lcd_disp.sv
// Shows the latest ADC0809 sample as "ADC=ddd" on an HD44780 LCD (8-bit, write-only).
// Sequential double-dabble conversion; self-initialising LCD after reset.
module adc_lcd_disp #(
    parameter int PWR_WAIT = 1000000,
    parameter int E_HIGH   = 12,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int MAX_A    = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAX_B    = (CMD_WAIT > E_HIGH) ? CMD_WAIT : E_HIGH;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_CONV, S_WRITE} state_t;
    typedef enum logic [1:0] {P_SETUP, P_STROBE, P_WAIT} phase_t;

    state_t           r_state, w_state_nxt;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_slot, r_iter;
    logic             r_pending;
    logic [7:0]       r_hold, r_work;
    logic [11:0]      r_bcd;
    logic             r_rs;
    logic [7:0]       r_data;

    logic             w_in_slot, w_pwr_done, w_slot_done, w_last_slot;
    logic             w_conv_load, w_conv_done, w_start_slot;
    logic [CNT_W-1:0] w_wait_last;
    logic [2:0]       w_slot_sel;
    logic [8:0]       w_byte;
    logic [11:0]      w_bcd_adj;

    // Add 3 to every BCD nibble >= 5 before the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        end
        return r;
    endfunction

    // {rs, data} for a slot of the init sequence (wr=0) or of a display update (wr=1).
    function automatic logic [8:0] slot_byte(input logic wr, input logic [2:0] slot,
                                             input logic [11:0] bcd);
        logic [8:0] b;
        b = 9'h000;
        if (!wr) begin
            case (slot)
                3'd0:    b = {1'b0, 8'h38};
                3'd1:    b = {1'b0, 8'h0C};
                3'd2:    b = {1'b0, 8'h06};
                default: b = {1'b0, 8'h01};
            endcase
        end else begin
            case (slot)
                3'd0:    b = {1'b0, 8'h80};
                3'd1:    b = {1'b1, 8'h41};
                3'd2:    b = {1'b1, 8'h44};
                3'd3:    b = {1'b1, 8'h43};
                3'd4:    b = {1'b1, 8'h3D};
                3'd5:    b = {1'b1, 4'h3, bcd[11:8]};
                3'd6:    b = {1'b1, 4'h3, bcd[7:4]};
                default: b = {1'b1, 4'h3, bcd[3:0]};
            endcase
        end
        return b;
    endfunction

    always_comb begin
        w_in_slot    = (r_state == S_INIT) || (r_state == S_WRITE);
        w_pwr_done   = (r_state == S_PWR) && (r_cnt == CNT_W'(PWR_WAIT - 1));
        w_wait_last  = (!r_rs && r_data == 8'h01) ? CNT_W'(CLR_WAIT - 1) : CNT_W'(CMD_WAIT - 1);
        w_slot_done  = w_in_slot && (r_phase == P_WAIT) && (r_cnt == w_wait_last);
        w_last_slot  = (r_state == S_INIT) ? (r_slot == 3'd3) : (r_slot == 3'd7);
        w_conv_load  = (r_state == S_IDLE) && r_pending;
        w_conv_done  = (r_state == S_CONV) && (r_iter == 3'd7);
        w_start_slot = w_pwr_done || w_conv_done || (w_slot_done && !w_last_slot);
        w_slot_sel   = w_slot_done ? r_slot + 3'd1 : 3'd0;
        w_byte       = slot_byte((r_state == S_CONV) || (r_state == S_WRITE), w_slot_sel, r_bcd);
        w_bcd_adj    = dd_adjust(r_bcd);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_PWR;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PWR:   if (w_pwr_done) w_state_nxt = S_INIT;
            S_INIT:  if (w_slot_done && w_last_slot) w_state_nxt = S_IDLE;
            S_IDLE:  if (r_pending) w_state_nxt = S_CONV;
            S_CONV:  if (w_conv_done) w_state_nxt = S_WRITE;
            S_WRITE: if (w_slot_done && w_last_slot) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_PWR;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        lcd_e    = w_in_slot && (r_phase == P_STROBE);
        lcd_rs   = r_rs;
        lcd_rw   = 1'b0;
        lcd_data = r_data;
    end

    // Slot engine: setup (1) -> strobe (E_HIGH) -> wait; rs/data held until the next setup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= P_SETUP;
            r_cnt   <= '0;
            r_slot  <= 3'd0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else if (w_start_slot) begin
            r_phase         <= P_SETUP;
            r_cnt           <= '0;
            r_slot          <= w_slot_sel;
            {r_rs, r_data}  <= w_byte;
        end else if (w_in_slot) begin
            case (r_phase)
                P_SETUP: begin
                    r_phase <= P_STROBE;
                    r_cnt   <= '0;
                end
                P_STROBE: begin
                    if (r_cnt == CNT_W'(E_HIGH - 1)) begin
                        r_phase <= P_WAIT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= r_cnt + CNT_W'(1);
            endcase
        end else if (r_state == S_PWR) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // A strobe coinciding with the conversion load keeps pending set (newest sample wins).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_hold    <= 8'h00;
            r_work    <= 8'h00;
            r_bcd     <= 12'h000;
            r_iter    <= 3'd0;
        end else begin
            if (sample_valid) begin
                r_hold    <= sample;
                r_pending <= 1'b1;
            end else if (w_conv_load) begin
                r_pending <= 1'b0;
            end
            if (w_conv_load) begin
                r_work <= r_hold;
                r_bcd  <= 12'h000;
                r_iter <= 3'd0;
            end else if (r_state == S_CONV) begin
                r_bcd  <= {w_bcd_adj[10:0], r_work[7]};
                r_work <= {r_work[6:0], 1'b0};
                r_iter <= r_iter + 3'd1;
            end
        end
    end
endmodule
